// File: rtl/pulse_debounce_bank.sv
// pulse_debounce_bank
//   Multi-channel button front end. Each channel passes its raw input through
//   a 2-flop synchroniser, then a debounce filter. The filter accepts a new
//   level only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
//   Each debounced press produces a one-cycle pulse. Channels do not interact.
//
//   Optional feature, macro AUTO_REPEAT_EN: while a channel stays pressed it
//   emits extra pulses. The first extra pulse comes REPEAT_DELAY cycles after
//   the press pulse, and later ones follow every REPEAT_PERIOD cycles. Without
//   the macro there is no repeat logic and each press gives exactly one pulse.
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   btn_in     in   N  raw asynchronous button inputs
//   level_out  out  N  debounced pressed level (1 = pressed)
//   pulse_out  out  N  one-cycle press pulse (plus repeats when enabled)
module pulse_debounce_bank #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] level_out,
    output logic [N-1:0] pulse_out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // The polarity is corrected before the first flop, so every later stage
    // works with 1 = pressed.
    localparam logic [N-1:0] POLARITY = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    logic [N-1:0]  sync_a;
    logic [N-1:0]  sync_b;
    logic [N-1:0]  level;
    logic [N-1:0]  pulse;
    logic [CW-1:0] cnt [N];

    logic [N-1:0]  accept;
    logic [N-1:0]  press;
    logic [N-1:0]  release_edge;
    logic [N-1:0]  repeat_fire;

    // The mismatch has lasted long enough, so the level flips on this edge.
    always_comb begin
        accept       = '0;
        press        = '0;
        release_edge = '0;
        for (int i = 0; i < N; i++) begin
            accept[i]       = (sync_b[i] != level[i]) && (cnt[i] == CNT_LAST);
            press[i]        = accept[i] & sync_b[i];
            release_edge[i] = accept[i] & ~sync_b[i];
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    // rcnt holds the number of cycles since the last pulse on this channel,
    // minus one. rphase is 0 until the first repeat and 1 after it.
    logic [RW-1:0] rcnt [N];
    logic [N-1:0]  rphase;

    // A repeat fires only if the level stays high through this edge. A release
    // that lands on the same edge suppresses the repeat.
    always_comb begin
        repeat_fire = '0;
        for (int i = 0; i < N; i++) begin
            repeat_fire[i] = level[i] & ~release_edge[i] &
                             (rcnt[i] == (rphase[i] ? PERIOD_LAST : DELAY_LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rphase <= '0;
            for (int i = 0; i < N; i++) rcnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!level[i] || release_edge[i]) begin
                    rcnt[i]   <= '0;
                    rphase[i] <= 1'b0;
                end else if (repeat_fire[i]) begin
                    rcnt[i]   <= '0;
                    rphase[i] <= 1'b1;
                end else begin
                    rcnt[i]   <= rcnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        repeat_fire = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
            level  <= '0;
            pulse  <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            sync_a <= btn_in ^ POLARITY;
            sync_b <= sync_a;
            for (int i = 0; i < N; i++) begin
                if (sync_b[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    level[i] <= sync_b[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i]   <= cnt[i] + 1'b1;
                end
            end
            // The press pulse is registered on the same edge as the 0->1 level update.
            pulse <= press | repeat_fire;
        end
    end

    assign level_out = level;
    assign pulse_out = pulse;

endmodule

// File: tb/tb_pulse_debounce_bank.sv
// tb_pulse_debounce_bank
//   Directed scenarios followed by randomized button activity. Two instances
//   are driven: an active-high one and an active-low one. Their outputs are
//   compared every cycle against a reference model. The model keeps a window
//   of the last DEBOUNCE_CYCLES synchronised samples, and it counts repeat
//   pulses as the elapsed time since the press.
module tb_pulse_debounce_bank;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;
`ifdef AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] btn;
    logic [N-1:0] btn_al;
    logic [N-1:0] level_h, pulse_h, level_l, pulse_l;

    int tests = 0;
    int fails = 0;

    pulse_debounce_bank #(.N(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0),
                          .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset(reset), .btn_in(btn),
        .level_out(level_h), .pulse_out(pulse_h));

    pulse_debounce_bank #(.N(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1),
                          .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_al (
        .clk(clk), .reset(reset), .btn_in(btn_al),
        .level_out(level_l), .pulse_out(pulse_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, indexed [instance][channel].
    bit [N-1:0] m_s1 [2];
    bit [N-1:0] m_s2 [2];
    bit [N-1:0] m_level [2];
    bit [N-1:0] m_pulse [2];
    bit         m_win [2][N][D];
    int         m_elapsed [2][N];

    function automatic void model_step(int k, logic [N-1:0] raw, logic rst);
        bit [N-1:0] corr;
        bit         s_cur, all_new, new_lvl;
        corr = (k == 1) ? ~raw : raw;
        if (rst) begin
            m_s1[k] = '0; m_s2[k] = '0; m_level[k] = '0; m_pulse[k] = '0;
            for (int i = 0; i < N; i++) begin
                m_elapsed[k][i] = 0;
                for (int j = 0; j < D; j++) m_win[k][i][j] = 1'b0;
            end
            return;
        end
        for (int i = 0; i < N; i++) begin
            s_cur = m_s2[k][i];
            for (int j = D - 1; j > 0; j--) m_win[k][i][j] = m_win[k][i][j-1];
            m_win[k][i][0] = s_cur;
            all_new = 1'b1;
            for (int j = 0; j < D; j++)
                if (m_win[k][i][j] == m_level[k][i]) all_new = 1'b0;
            new_lvl = all_new ? ~m_level[k][i] : m_level[k][i];
            m_pulse[k][i] = 1'b0;
            if (new_lvl && !m_level[k][i]) begin
                m_pulse[k][i]   = 1'b1;
                m_elapsed[k][i] = 0;
            end else if (new_lvl && m_level[k][i]) begin
                m_elapsed[k][i]++;
                if (REP && (m_elapsed[k][i] == RD ||
                            (m_elapsed[k][i] > RD && (m_elapsed[k][i] - RD) % RP == 0)))
                    m_pulse[k][i] = 1'b1;
            end else begin
                m_elapsed[k][i] = 0;
            end
            m_level[k][i] = new_lvl;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = corr;
    endfunction

    task automatic check(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge, step the model with the inputs sampled there, then
    // compare both instances shortly after the edge.
    task automatic tick();
        @(posedge clk);
        model_step(0, btn, reset);
        model_step(1, btn_al, reset);
        #1;
        check("level_hi", level_h, m_level[0]);
        check("pulse_hi", pulse_h, m_pulse[0]);
        check("level_lo", level_l, m_level[1]);
        check("pulse_lo", pulse_l, m_pulse[1]);
    endtask

    task automatic ticks(int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    int hold [N];
    int hold_al [N];

    initial begin
        reset  = 1'b1;
        btn    = '0;
        btn_al = '1;
        // Reset with idle inputs.
        ticks(3);
        reset = 1'b0;
        ticks(4);
        check("idle_level", level_h, 4'b0000);
        check("idle_pulse", pulse_h, 4'b0000);

        // Single press on channel 0: level and pulse rise at E5.
        btn[0] = 1'b1;
        ticks(5);
        check("e4_level0", {3'b000, level_h[0]}, 4'b0000);
        tick();
        check("e5_level0", {3'b000, level_h[0]}, 4'b0001);
        check("e5_pulse0", {3'b000, pulse_h[0]}, 4'b0001);
        tick();
        check("e6_pulse0", {3'b000, pulse_h[0]}, 4'b0000);
        ticks(13);
        btn[0] = 1'b0;
        ticks(8);

        // Short glitch on channel 1 is rejected.
        btn[1] = 1'b1;
        ticks(3);
        btn[1] = 1'b0;
        ticks(8);

        // Bouncing channel 2, then stable press and release.
        btn[2] = 1'b1; tick();
        btn[2] = 1'b0; tick();
        btn[2] = 1'b1; tick();
        btn[2] = 1'b0; tick();
        btn[2] = 1'b1;
        ticks(12);
        btn[2] = 1'b0;
        ticks(8);

        // Simultaneous press on channels 0 and 3.
        btn = 4'b1001;
        ticks(6);
        check("dual_pulse", pulse_h, 4'b1001);
        ticks(4);
        btn = '0;
        ticks(8);

        // Long hold with reset asserted mid-hold, then held through deassert.
        btn[0] = 1'b1;
        ticks(6);
        ticks(11);
        reset = 1'b1;
        tick();
        check("rst_level", level_h, 4'b0000);
        check("rst_pulse", pulse_h, 4'b0000);
        reset = 1'b0;
        ticks(12);
        btn[0] = 1'b0;
        ticks(8);

        // Randomized activity on both instances with occasional resets.
        for (int i = 0; i < N; i++) begin
            hold[i] = 0;
            hold_al[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    btn[i]  = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 12));
                end
                hold[i]--;
                if (hold_al[i] == 0) begin
                    btn_al[i]  = 1'($urandom_range(0, 1));
                    hold_al[i] = int'($urandom_range(1, 12));
                end
                hold_al[i]--;
            end
            reset = ($urandom_range(0, 99) < 2);
            tick();
        end
        reset = 1'b0;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
